// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Includes the FSM encoding, the transaction type values and the per-port request bundle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  typedef struct packed {
    logic        val;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Round-robin: on a tie the port that did not win last time goes next.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// When the counter reaches all-ones it holds that value instead of wrapping.
module SatCounter #(
  parameter int p_width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [p_width-1:0] count
);

  localparam logic [p_width-1:0] CNT_MAX = '1;

  logic [p_width-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + p_width'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory port.
// Grant is combinational, round-robin on ties, and held while memory stalls a transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_val,
  output logic                   req0_wait,
  input  logic                   req0_type,
  input  logic [31:0]            req0_addr,
  input  logic [31:0]            req0_wdata,
  output logic [31:0]            req0_rdata,
  input  logic                   req1_val,
  output logic                   req1_wait,
  input  logic                   req1_type,
  input  logic [31:0]            req1_addr,
  input  logic [31:0]            req1_wdata,
  output logic [31:0]            req1_rdata,
  output logic                   mem_val,
  input  logic                   mem_wait,
  output logic                   mem_type,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [p_cnt_nbits-1:0] grant_cnt0,
  output logic [p_cnt_nbits-1:0] grant_cnt1
);

  arb_state_t state_reg, state_next;
  logic       ptr_reg, ptr_next;

  mem_req_t   req0_bundle, req1_bundle, granted;
  logic       grant_valid;
  logic       grant_port;
  logic       complete;
  logic [1:0] port_inc;
  logic [p_cnt_nbits-1:0] cnt [2];

  assign req0_bundle = '{val: req0_val, typ: req0_type, addr: req0_addr, wdata: req0_wdata};
  assign req1_bundle = '{val: req1_val, typ: req1_type, addr: req1_addr, wdata: req1_wdata};

  // A locked port keeps the grant even if it drops val; the drop then just releases the lock.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_IFETCH;
    case (state_reg)
      ST_LOCK0: begin
        grant_valid = 1'b1;
        grant_port  = PORT_IFETCH;
      end
      ST_LOCK1: begin
        grant_valid = 1'b1;
        grant_port  = PORT_DATA;
      end
      default: begin
        if (req0_val && req1_val) begin
          grant_valid = 1'b1;
          grant_port  = other_port(ptr_reg);
        end else if (req0_val) begin
          grant_valid = 1'b1;
          grant_port  = PORT_IFETCH;
        end else if (req1_val) begin
          grant_valid = 1'b1;
          grant_port  = PORT_DATA;
        end
      end
    endcase
    if (rst) begin
      grant_valid = 1'b0;
    end
  end

  assign granted  = grant_port ? req1_bundle : req0_bundle;
  assign complete = grant_valid && granted.val && !mem_wait;

  assign mem_val   = grant_valid && granted.val;
  assign mem_type  = granted.typ;
  assign mem_addr  = granted.addr;
  assign mem_wdata = granted.wdata;

  assign req0_rdata = mem_rdata;
  assign req1_rdata = mem_rdata;

  assign req0_wait = (grant_valid && (grant_port == PORT_IFETCH)) ? mem_wait : 1'b1;
  assign req1_wait = (grant_valid && (grant_port == PORT_DATA))   ? mem_wait : 1'b1;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid && granted.val && mem_wait) begin
          state_next = (grant_port == PORT_DATA) ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (!granted.val || !mem_wait) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (complete) begin
      ptr_next = grant_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= PORT_DATA;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign port_inc[0] = complete && (grant_port == PORT_IFETCH);
  assign port_inc[1] = complete && (grant_port == PORT_DATA);

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    SatCounter #(
      .p_width (p_cnt_nbits)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (port_inc[gi]),
      .count (cnt[gi])
    );
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];

endmodule
